// File: rtl/nested_if_decoder.sv
// Serial line-symbol decoder: assembles MSB-first bit symbols into WIDTH-bit words
// and holds each word until the consumer handshakes. It also flags illegal symbols and dropped bits.
module nested_if_decoder #(
    parameter int WIDTH = 8,
    parameter int ERRW  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       b,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             err,
    output logic             overrun,
    output logic [ERRW-1:0]  err_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    logic is_bit;
    logic is_illegal;
    logic bit_val;

    assign is_bit     = b[1];
    assign is_illegal = (b == 2'd1);
    assign bit_val    = b[1] & ~b[0];

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            data      <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            err     <= is_illegal;
            overrun <= 1'b0;
            if (is_illegal)
                err_count <= sat_inc(err_count);

            case (state)
                IDLE: begin
                    if (is_bit) begin
                        sreg  <= {{(WIDTH-1){1'b0}}, bit_val};
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (is_bit) begin
                        if (cnt == LAST) begin
                            data  <= {sreg[WIDTH-2:0], bit_val};
                            valid <= 1'b1;
                            cnt   <= FULL;
                            state <= HOLD;
                        end else begin
                            sreg <= {sreg[WIDTH-2:0], bit_val};
                            cnt  <= cnt + 1'b1;
                        end
                    end else begin
                        // Idle aborts and illegal symbols both drop the partial word silently.
                        sreg  <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (is_bit) begin
                            sreg  <= {{(WIDTH-1){1'b0}}, bit_val};
                            cnt   <= CW'(1);
                            state <= SHIFT;
                        end else begin
                            sreg  <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else if (is_bit) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nested_if_decoder.sv
// Randomized and directed bench for nested_if_decoder against a queue-based word model.
module tb_nested_if_decoder;

    localparam int W = 8;
    localparam int E = 4;

    logic         clock;
    logic         reset;
    logic [1:0]   b;
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         err;
    logic         overrun;
    logic [E-1:0] err_count;

    nested_if_decoder #(.WIDTH(W), .ERRW(E)) dut (
        .clock(clock), .reset(reset), .b(b), .data(data), .valid(valid),
        .ready(ready), .err(err), .overrun(overrun), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;

    // Reference model: received bits of the word in progress, plus a pending word.
    int           bits[$];
    bit           have_word;
    logic [W-1:0] exp_data;
    logic         exp_valid, exp_err, exp_ovr;
    int           errs;
    int           err_seen, ovr_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int sym, input bit rdy, input bit rst);
        int v;
        if (!rst) begin
            bits.delete();
            have_word = 0;
            exp_data = '0; exp_valid = 0; exp_err = 0; exp_ovr = 0; errs = 0;
            return;
        end
        exp_err = (sym == 1);
        exp_ovr = 0;
        if (sym == 1) errs = (errs + 1 > (1 << E) - 1) ? (1 << E) - 1 : errs + 1;
        if (have_word) begin
            if (rdy) begin
                have_word = 0;
                exp_valid = 0;
                bits.delete();
                if (sym >= 2) bits.push_back(sym == 2 ? 1 : 0);
            end else if (sym >= 2) begin
                exp_ovr = 1;
            end
        end else if (sym >= 2) begin
            bits.push_back(sym == 2 ? 1 : 0);
            if (bits.size() == W) begin
                v = 0;
                for (int i = 0; i < W; i++) v = v + (bits[i] << (W - 1 - i));
                exp_data = W'(v);
                exp_valid = 1;
                have_word = 1;
                bits.delete();
            end
        end else begin
            bits.delete();
        end
    endtask

    task automatic cyc(input int sym, input bit rdy, input bit rst);
        b = 2'(sym); ready = rdy; reset = rst;
        @(posedge clock);
        model(sym, rdy, rst);
        #1;
        check("data", 32'(data), 32'(exp_data));
        check("valid", 32'(valid), 32'(exp_valid));
        check("err", 32'(err), 32'(exp_err));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("err_count", 32'(err_count), 32'(errs));
        if (err) err_seen++;
        if (overrun) ovr_seen++;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy);
        for (int i = W - 1; i >= 0; i--) cyc(w[i] ? 2 : 3, rdy, 1);
    endtask

    initial begin
        b = 0; ready = 0; reset = 0;
        errs = 0; have_word = 0; exp_data = '0; exp_valid = 0; exp_err = 0; exp_ovr = 0;
        err_seen = 0; ovr_seen = 0;

        // Reset state
        for (int i = 0; i < 3; i++) cyc($urandom_range(0, 3), 1'($urandom), 0);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);

        // A5 with ready high: valid for exactly one cycle
        send_word(8'hA5, 1);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_valid", 32'(valid), 32'h1);
        cyc(0, 1, 1);
        check("a5_valid_drop", 32'(valid), 32'h0);

        // A5 held while ready low, two bits dropped
        send_word(8'hA5, 0);
        ovr_seen = 0;
        cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1); cyc(2, 0, 1); cyc(2, 0, 1);
        check("hold_data", 32'(data), 32'hA5);
        check("overrun_count", 32'(ovr_seen), 32'd2);
        cyc(1, 0, 1);
        check("hold_valid_err", 32'(valid), 32'h1);
        cyc(0, 1, 1);
        check("hold_accept", 32'(valid), 32'h0);

        // Abort of a partial word, then all-zero word
        err_seen = 0;
        cyc(2, 1, 1); cyc(2, 1, 1); cyc(2, 1, 1); cyc(0, 1, 1);
        for (int i = 0; i < W; i++) cyc(3, 0, 1);
        check("zero_data", 32'(data), 32'h00);
        check("zero_valid", 32'(valid), 32'h1);
        check("zero_noerr", 32'(err_seen), 32'd0);
        cyc(0, 1, 1);

        // Error counter saturation
        err_seen = 0;
        for (int i = 0; i < 17; i++) cyc(1, 1, 1);
        cyc(0, 1, 1);
        check("err_pulses", 32'(err_seen), 32'd17);
        check("err_sat", 32'(err_count), 32'hF);

        // Reset mid-word
        for (int i = 0; i < 5; i++) cyc(2, 1, 1);
        cyc(3, 1, 0); cyc(2, 1, 0);
        check("midrst_zero", 32'({data, valid, err, overrun, err_count}), 32'h0);
        send_word(8'h3C, 0);
        check("post_rst_data", 32'(data), 32'h3C);

        // Handshake with simultaneous bit starts the next word
        cyc(3, 1, 1);
        check("hs_valid", 32'(valid), 32'h0);
        for (int i = 0; i < W - 1; i++) cyc(2, 1, 1);
        check("hs_next_data", 32'(data), 32'h7F);
        cyc(0, 1, 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 9) < 2 ? $urandom_range(0, 1) : $urandom_range(2, 3),
                1'($urandom_range(0, 2) == 0), $urandom_range(0, 60) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nested_if_decoder.md
NESTED_IF_DECODER -- requirements
Module: nested_if_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of decoded bits per word (legal range 2..16).
REQ-002 SHALL have parameter ERRW, default 4, giving the width of the error counter.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 SHALL have port b, input, 2 bits: line symbol sampled every cycle (0 = idle, 1 = illegal, 2 = bit 1, 3 = bit 0).
REQ-006 SHALL have port data, output, WIDTH bits: decoded word, with the first received bit in data[WIDTH-1].
REQ-007 SHALL have port valid, output, 1 bit: data holds a complete word.
REQ-008 SHALL have port ready, input, 1 bit: the consumer accepts data when valid and ready are both high.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse when symbol 1 is sampled.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a bit symbol is dropped in HOLD.
REQ-011 SHALL have port err_count, output, ERRW bits: saturating count of err pulses.

Function
REQ-012 SHALL implement the states IDLE, SHIFT and HOLD.
REQ-013 IDLE: on symbol 2 or 3, SHALL load that bit into the shift register, set bit count to 1 and enter SHIFT; on symbol 0, SHALL stay in IDLE.
REQ-014 SHIFT: on symbol 2 or 3, SHALL shift the bit in MSB-first and increment the count.
REQ-015 SHIFT: when the count reaches WIDTH, SHALL enter HOLD and drive data and valid=1 on the next cycle (latency 1 cycle after the last bit is sampled).
REQ-016 SHIFT: on symbol 0 (abort), SHALL discard the partial word and return to IDLE with no pulse.
REQ-017 Any state: on symbol 1, SHALL pulse err the following cycle and increment err_count, saturating at all-ones.
REQ-018 Symbol 1 in SHIFT SHALL discard the partial word and return to IDLE.
REQ-019 Symbol 1 in HOLD SHALL NOT disturb data or valid.
REQ-020 HOLD: data and valid SHALL stay stable until the cycle in which valid and ready are both high (handshake).
REQ-021 HOLD: a bit symbol sampled while no handshake occurs SHALL be dropped and SHALL pulse overrun the following cycle.
REQ-022 HOLD with handshake and a simultaneous bit symbol: SHALL accept the symbol as bit 1 of a new word and enter SHIFT (no overrun).
REQ-023 HOLD with handshake and symbol 0 or 1: SHALL enter IDLE, with symbol 1 also handled per REQ-017.
REQ-024 valid SHALL be low in IDLE and SHIFT.
REQ-025 ready SHALL be ignored while valid=0.
REQ-026 data SHALL be registered.
REQ-027 data SHALL hold its last delivered value outside HOLD.
REQ-028 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE, data=0, valid=0, err=0, overrun=0, err_count=0, and clear the shift register and counter.
REQ-030 Reset SHALL take priority over every other event, including mid-SHIFT and in HOLD awaiting ready; partial or pending words are lost.
REQ-031 After reset is released, the first symbol SHALL be processed on the next edge.

Verification
REQ-032 Symbols 2,3,2,3,3,2,3,2 with ready=1 -> data=8'hA5, valid=1 for exactly one cycle, one cycle after the 8th symbol.
REQ-033 Same word with ready=0 for 5 cycles, then symbols 2,2 during the wait -> data stays 8'hA5, overrun pulses twice, accept on ready=1.
REQ-034 Symbols 2,2,2 then 0, then eight 3s -> first partial word discarded; data=8'h00 delivered, no err.
REQ-035 Symbol 1 sampled 17 times with ERRW=4 -> err pulses 17 times; err_count saturates at 4'hF.
REQ-036 reset=0 while in SHIFT after 5 bits, then a full word -> outputs all 0 during reset; next word decodes correctly with no leftover bits.
REQ-037 In HOLD, ready=1 and symbol 3 in the same cycle -> valid drops, SHIFT entered with count 1; next word's MSB=0.
